// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Execute-stage branch/jump resolution for the RV32I pipeline. It evaluates
// the branch condition, computes the architectural next PC, and compares the
// result against the front-end prediction. The result is held in a single
// output register. After a mispredict, wrong-path requests are discarded for
// SQUASH_CYC cycles. Two saturating counters track resolved branches and
// mispredicts.
//
// Handshake: a request transfers on a rising edge when i_valid && o_ready.
// o_ready is simply !i_stall, so it never depends on i_valid. A transfer with
// i_flush high, or during the squash shadow, is consumed but produces no
// result. o_valid marks one registered result. The result stays for exactly
// one cycle, or for longer while i_stall holds the output register.
module branch_resolve_unit #(
   parameter int XLEN       = 32,
   parameter int CNT_W      = 16,
   parameter int SQUASH_CYC = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_stall,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_is_jal,
   input  logic             i_is_jalr,
   input  logic [2:0]       i_funct3,
   input  logic [XLEN-1:0]  i_rs1,
   input  logic [XLEN-1:0]  i_rs2,
   input  logic [XLEN-1:0]  i_pc,
   input  logic [XLEN-1:0]  i_imm,
   input  logic             i_pred_taken,
   input  logic [XLEN-1:0]  i_pred_target,
   output logic             o_valid,
   output logic             o_taken,
   output logic [XLEN-1:0]  o_next_pc,
   output logic             o_mispredict,
   output logic             o_illegal,
   output logic [CNT_W-1:0] o_br_cnt,
   output logic [CNT_W-1:0] o_mis_cnt,
   output logic [0:0]       o_dbg_state
);

   // FSM encodings
   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_SHADOW = 1'b1;

   // Shadow length fits in 4 bits (1..15)
   localparam logic [3:0]      SQ_LOAD = 4'(SQUASH_CYC);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   // funct3 encodings of the conditional branches
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   logic [0:0] state;
   logic [3:0] sq_cnt;

   // ------------------------------------------------------------------
   // Request decode. When both jump flags are set, JALR wins.
   // ------------------------------------------------------------------
   logic is_jalr;
   logic is_jal;
   logic is_cond;

   assign is_jalr = i_is_jalr;
   assign is_jal  = i_is_jal & ~i_is_jalr;
   assign is_cond = ~i_is_jal & ~i_is_jalr;

   // ------------------------------------------------------------------
   // Magnitude compare. The signed compare reuses the unsigned comparator:
   // flipping both sign bits maps two's-complement order onto unsigned
   // order.
   // ------------------------------------------------------------------
   logic [XLEN-1:0] cmp_a_s;
   logic [XLEN-1:0] cmp_b_s;
   logic            op_eq;
   logic            op_lt_u;
   logic            op_lt_s;

   assign cmp_a_s = {~i_rs1[XLEN-1], i_rs1[XLEN-2:0]};
   assign cmp_b_s = {~i_rs2[XLEN-1], i_rs2[XLEN-2:0]};
   assign op_eq   = (i_rs1 == i_rs2);
   assign op_lt_u = (i_rs1 < i_rs2);
   assign op_lt_s = (cmp_a_s < cmp_b_s);

   // Conditional-branch outcome. Reserved funct3 values resolve not-taken
   // and are flagged illegal.
   logic cond_taken;
   logic cond_illegal;

   // Evaluate the branch condition selected by funct3
   always_comb begin
      cond_taken   = 1'b0;
      cond_illegal = 1'b0;
      case (i_funct3)
         F3_BEQ:  cond_taken = op_eq;
         F3_BNE:  cond_taken = ~op_eq;
         F3_BLT:  cond_taken = op_lt_s;
         F3_BGE:  cond_taken = ~op_lt_s;
         F3_BLTU: cond_taken = op_lt_u;
         F3_BGEU: cond_taken = ~op_lt_u;
         default: begin
            cond_taken   = 1'b0;
            cond_illegal = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Target and fall-through addresses. All sums wrap mod 2^XLEN.
   // ------------------------------------------------------------------
   logic [XLEN-1:0] pc_plus_imm;
   logic [XLEN-1:0] rs1_plus_imm;
   logic [XLEN-1:0] pc_plus_4;
   logic [XLEN-1:0] jalr_target;

   assign pc_plus_imm  = i_pc + i_imm;
   assign rs1_plus_imm = i_rs1 + i_imm;
   assign pc_plus_4    = i_pc + PC_STEP;
   assign jalr_target  = {rs1_plus_imm[XLEN-1:1], 1'b0};

   // ------------------------------------------------------------------
   // Combinational resolution of the presented request
   // ------------------------------------------------------------------
   logic            res_taken;
   logic            res_illegal;
   logic [XLEN-1:0] res_target;
   logic [XLEN-1:0] res_next_pc;
   logic            res_mispredict;

   // Select the direction and target for the request kind
   always_comb begin
      res_taken   = 1'b0;
      res_illegal = 1'b0;
      res_target  = pc_plus_imm;
      if (is_jalr) begin
         res_taken  = 1'b1;
         res_target = jalr_target;
      end else if (is_jal) begin
         res_taken  = 1'b1;
         res_target = pc_plus_imm;
      end else if (is_cond) begin
         res_taken   = cond_taken;
         res_illegal = cond_illegal;
         res_target  = pc_plus_imm;
      end
   end

   assign res_next_pc    = res_taken ? res_target : pc_plus_4;
   assign res_mispredict = (res_taken != i_pred_taken) ||
                           (res_taken && (i_pred_target != res_target));

   // ------------------------------------------------------------------
   // Acceptance. A result is registered only outside the shadow and
   // without a flush. Squashed transfers are still consumed.
   // ------------------------------------------------------------------
   logic accept;
   logic result_load;
   logic mis_load;

   assign o_ready     = ~i_stall;
   assign accept      = i_valid & o_ready;
   assign result_load = accept & ~i_flush & (state == ST_RUN);
   assign mis_load    = result_load & res_mispredict;

   // Output register: flush clears, stall holds, otherwise load or drain
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid      <= 1'b0;
         o_taken      <= 1'b0;
         o_next_pc    <= '0;
         o_mispredict <= 1'b0;
         o_illegal    <= 1'b0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else if (!i_stall) begin
         if (result_load) begin
            o_valid      <= 1'b1;
            o_taken      <= res_taken;
            o_next_pc    <= res_next_pc;
            o_mispredict <= res_mispredict;
            o_illegal    <= res_illegal;
         end else begin
            o_valid <= 1'b0;
         end
      end
   end

   // Shadow FSM: a registered mispredict opens a SQUASH_CYC-cycle window
   // that counts down every cycle, stalled or not
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= ST_RUN;
         sq_cnt <= 4'd0;
      end else if (i_flush) begin
         state  <= ST_RUN;
         sq_cnt <= 4'd0;
      end else begin
         case (state)
            ST_RUN: begin
               if (mis_load) begin
                  state  <= ST_SHADOW;
                  sq_cnt <= SQ_LOAD;
               end
            end
            ST_SHADOW: begin
               if (sq_cnt <= 4'd1) begin
                  state  <= ST_RUN;
                  sq_cnt <= 4'd0;
               end else begin
                  sq_cnt <= sq_cnt - 4'd1;
               end
            end
            default: begin
               state  <= ST_RUN;
               sq_cnt <= 4'd0;
            end
         endcase
      end
   end

   assign o_dbg_state = state;

   // Statistics counters saturate at all-ones. Flush and squash leave them
   // alone; only reset clears them.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_br_cnt  <= '0;
         o_mis_cnt <= '0;
      end else begin
         if (result_load && (o_br_cnt != {CNT_W{1'b1}})) begin
            o_br_cnt <= o_br_cnt + 1'b1;
         end
         if (mis_load && (o_mis_cnt != {CNT_W{1'b1}})) begin
            o_mis_cnt <= o_mis_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
// Self-checking bench for branch_resolve_unit, built with CNT_W=4 and
// SQUASH_CYC=2. A behavioural model pushes expected results into exp_q at
// each clock edge. Each test task pops those results and compares them
// inline.
module tb_branch_resolve_unit;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int SQ    = 2;

   // Expected result: {taken, illegal, mispredict, next_pc}
   typedef struct packed {
      logic        taken;
      logic        ill;
      logic        mis;
      logic [31:0] next_pc;
      logic [31:0] target;
   } res_t;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             stall;
   logic             valid;
   logic             ready;
   logic             is_jal;
   logic             is_jalr;
   logic [2:0]       funct3;
   logic [XLEN-1:0]  rs1;
   logic [XLEN-1:0]  rs2;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  imm;
   logic             pred_taken;
   logic [XLEN-1:0]  pred_target;
   logic             o_valid;
   logic             o_taken;
   logic [XLEN-1:0]  o_next_pc;
   logic             o_mispredict;
   logic             o_illegal;
   logic [CNT_W-1:0] o_br_cnt;
   logic [CNT_W-1:0] o_mis_cnt;
   logic [0:0]       o_dbg_state;

   logic [34:0] exp_q[$];
   logic [34:0] held_e;
   int          n_checks;
   int          n_fail;

   // Model state
   logic        m_vld;
   logic        m_new;
   int          m_sh;
   int          m_br;
   int          m_mis;

   branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W), .SQUASH_CYC(SQ)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_flush       (flush),
      .i_stall       (stall),
      .i_valid       (valid),
      .o_ready       (ready),
      .i_is_jal      (is_jal),
      .i_is_jalr     (is_jalr),
      .i_funct3      (funct3),
      .i_rs1         (rs1),
      .i_rs2         (rs2),
      .i_pc          (pc),
      .i_imm         (imm),
      .i_pred_taken  (pred_taken),
      .i_pred_target (pred_target),
      .o_valid       (o_valid),
      .o_taken       (o_taken),
      .o_next_pc     (o_next_pc),
      .o_mispredict  (o_mispredict),
      .o_illegal     (o_illegal),
      .o_br_cnt      (o_br_cnt),
      .o_mis_cnt     (o_mis_cnt),
      .o_dbg_state   (o_dbg_state)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference resolution, written from the ISA definition
   function automatic res_t ref_resolve(logic jal, logic jalr, logic [2:0] f3,
                                        logic [31:0] a, logic [31:0] b,
                                        logic [31:0] p, logic [31:0] im,
                                        logic pt, logic [31:0] ptgt);
      res_t r;
      r = '0;
      if (jalr) begin
         r.taken  = 1'b1;
         r.target = (a + im) & 32'hFFFF_FFFE;
      end else if (jal) begin
         r.taken  = 1'b1;
         r.target = p + im;
      end else begin
         r.target = p + im;
         case (f3)
            3'd0: r.taken = (a == b);
            3'd1: r.taken = (a != b);
            3'd4: r.taken = ($signed(a) <  $signed(b));
            3'd5: r.taken = ($signed(a) >= $signed(b));
            3'd6: r.taken = (a <  b);
            3'd7: r.taken = (a >= b);
            default: begin r.taken = 1'b0; r.ill = 1'b1; end
         endcase
      end
      r.next_pc = r.taken ? r.target : p + 32'd4;
      r.mis     = (r.taken != pt) || (r.taken && (ptgt != r.target));
      return r;
   endfunction

   function automatic res_t cur_ref();
      return ref_resolve(is_jal, is_jalr, funct3, rs1, rs2, pc, imm, pred_taken, pred_target);
   endfunction

   // Driver tasks
   task automatic set_idle();
      valid = 1'b0; stall = 1'b0; flush = 1'b0;
      is_jal = 1'b0; is_jalr = 1'b0; funct3 = 3'd0;
      rs1 = '0; rs2 = '0; pc = '0; imm = '0;
      pred_taken = 1'b0; pred_target = '0;
   endtask

   task automatic drive_req(input logic jal, input logic jalr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] p, input logic [31:0] im,
                            input logic pt, input logic [31:0] ptgt);
      valid = 1'b1; is_jal = jal; is_jalr = jalr; funct3 = f3;
      rs1 = a; rs2 = b; pc = p; imm = im; pred_taken = pt; pred_target = ptgt;
   endtask

   // Overwrite the prediction with the correct one, so that no shadow opens
   task automatic predict_right();
      res_t r;
      r = cur_ref();
      pred_taken  = r.taken;
      pred_target = r.target;
   endtask

   task automatic model_reset();
      m_vld = 1'b0; m_new = 1'b0; m_sh = 0; m_br = 0; m_mis = 0;
      exp_q.delete();
   endtask

   // One clock edge. The model sees the same inputs that the DUT samples.
   task automatic tick();
      res_t r;
      r = '0;
      @(posedge clk);
      m_new = 1'b0;
      if (flush) begin
         m_vld = 1'b0;
         m_sh  = 0;
      end else begin
         if (!stall) begin
            if (valid && m_sh == 0) begin
               r = cur_ref();
               exp_q.push_back({r.taken, r.ill, r.mis, r.next_pc});
               m_new = 1'b1;
               m_vld = 1'b1;
               if (m_br  < 15) m_br++;
               if (r.mis && m_mis < 15) m_mis++;
            end else begin
               m_vld = 1'b0;
            end
         end
         if (m_sh > 0) m_sh--;
         else if (m_new && r.mis) m_sh = SQ;
      end
      #1;
   endtask

   task automatic test_reset();
      set_idle();
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      model_reset();
      @(posedge clk); #1;
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", o_valid); end
      n_checks++; if ({o_taken, o_mispredict, o_illegal} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %0h want 0", {o_taken, o_mispredict, o_illegal}); end
      n_checks++; if (o_next_pc !== 32'h0) begin n_fail++; $display("FAIL reset_next_pc: got %0h want 0", o_next_pc); end
      n_checks++; if ({o_br_cnt, o_mis_cnt} !== 8'h00) begin n_fail++; $display("FAIL reset_counters: got %0h want 0", {o_br_cnt, o_mis_cnt}); end
      n_checks++; if (o_dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %0h want 0", o_dbg_state); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_branch_cond();
      logic [34:0] e;
      // BLT: -1 < 1 signed, so the branch is taken. Predicted not-taken.
      drive_req(1'b0, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
      tick();
      e = exp_q.pop_front();
      n_checks++; if ({o_valid, o_taken, o_illegal, o_mispredict, o_next_pc} !== {1'b1, e}) begin n_fail++; $display("FAIL blt_result: got %0h want %0h", {o_valid, o_taken, o_illegal, o_mispredict, o_next_pc}, {1'b1, e}); end
      n_checks++; if (o_next_pc !== 32'h120 || o_mispredict !== 1'b1) begin n_fail++; $display("FAIL blt_const: got pc %0h mis %0h want 120 1", o_next_pc, o_mispredict); end
      n_checks++; if (o_br_cnt !== 4'd1 || o_mis_cnt !== 4'd1) begin n_fail++; $display("FAIL blt_counts: got %0d %0d want 1 1", o_br_cnt, o_mis_cnt); end
      set_idle();
      tick();
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL valid_drop: got %0h want 0", o_valid); end
      tick();
      // BLTU with the same operands: 0xFFFFFFFF is not below 1 unsigned
      drive_req(1'b0, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
      tick();
      e = exp_q.pop_front();
      n_checks++; if ({o_valid, o_taken, o_illegal, o_mispredict, o_next_pc} !== {1'b1, e}) begin n_fail++; $display("FAIL bltu_result: got %0h want %0h", {o_valid, o_taken, o_illegal, o_mispredict, o_next_pc}, {1'b1, e}); end
      n_checks++; if (o_taken !== 1'b0 || o_next_pc !== 32'h104 || o_mispredict !== 1'b0) begin n_fail++; $display("FAIL bltu_const: got %0h %0h %0h want 0 104 0", o_taken, o_next_pc, o_mispredict); end
      set_idle();
      tick();
   endtask

   task automatic test_jalr();
      logic [34:0] e;
      drive_req(1'b0, 1'b1, 3'b000, 32'h2003, 32'h0, 32'h500, 32'h10, 1'b1, 32'h2012);
      tick();
      e = exp_q.pop_front();
      n_checks++; if ({o_valid, o_taken, o_illegal, o_mispredict, o_next_pc} !== {1'b1, e}) begin n_fail++; $display("FAIL jalr_result: got %0h want %0h", {o_valid, o_taken, o_illegal, o_mispredict, o_next_pc}, {1'b1, e}); end
      n_checks++; if (o_next_pc !== 32'h2012 || o_mispredict !== 1'b0) begin n_fail++; $display("FAIL jalr_hit: got %0h %0h want 2012 0", o_next_pc, o_mispredict); end
      // Back-to-back accept. Both jump flags set is treated as JALR, with a wrong target.
      drive_req(1'b1, 1'b1, 3'b000, 32'h2003, 32'h0, 32'h500, 32'h10, 1'b1, 32'h2000);
      tick();
      e = exp_q.pop_front();
      n_checks++; if ({o_valid, o_taken, o_illegal, o_mispredict, o_next_pc} !== {1'b1, e}) begin n_fail++; $display("FAIL jalr_miss_result: got %0h want %0h", {o_valid, o_taken, o_illegal, o_mispredict, o_next_pc}, {1'b1, e}); end
      n_checks++; if (o_next_pc !== 32'h2012 || o_mispredict !== 1'b1) begin n_fail++; $display("FAIL jalr_miss: got %0h %0h want 2012 1", o_next_pc, o_mispredict); end
      set_idle();
      tick(); tick();
   endtask

   task automatic test_shadow();
      logic [34:0] e;
      logic [3:0]  br_before;
      drive_req(1'b0, 1'b0, 3'b000, 32'h5, 32'h5, 32'h300, 32'h8, 1'b0, 32'h0);
      tick();
      e = exp_q.pop_front();
      n_checks++; if (o_valid !== 1'b1 || o_mispredict !== 1'b1) begin n_fail++; $display("FAIL shadow_trigger: got %0h %0h want 1 1", o_valid, o_mispredict); end
      br_before = o_br_cnt;
      for (int i = 0; i < 3; i++) begin
         drive_req(1'b0, 1'b0, 3'b000, 32'h7, 32'h7, 32'h310 + 32'(i), 32'h40, 1'b1, 32'h0);
         predict_right();
         tick();
         if (i < 2) begin
            n_checks++; if (o_valid !== 1'b0 || o_br_cnt !== br_before) begin n_fail++; $display("FAIL shadow_squash%0d: got v %0h cnt %0d want 0 %0d", i, o_valid, o_br_cnt, br_before); end
         end else begin
            e = exp_q.pop_front();
            n_checks++; if ({o_valid, o_taken, o_illegal, o_mispredict, o_next_pc} !== {1'b1, e} || o_br_cnt !== br_before + 4'd1) begin n_fail++; $display("FAIL shadow_resume: got %0h cnt %0d want %0h cnt %0d", {o_valid, o_taken, o_illegal, o_mispredict, o_next_pc}, o_br_cnt, {1'b1, e}, br_before + 4'd1); end
         end
      end
      set_idle();
      tick();
   endtask

   task automatic test_illegal_stall_flush();
      logic [34:0] e;
      logic [3:0]  br_keep;
      logic [3:0]  mis_keep;
      drive_req(1'b0, 1'b0, 3'b010, 32'h1, 32'h1, 32'h400, 32'h8, 1'b1, 32'h408);
      tick();
      e = exp_q.pop_front();
      n_checks++; if ({o_valid, o_taken, o_illegal, o_mispredict, o_next_pc} !== {1'b1, e}) begin n_fail++; $display("FAIL illegal_result: got %0h want %0h", {o_valid, o_taken, o_illegal, o_mispredict, o_next_pc}, {1'b1, e}); end
      n_checks++; if (o_illegal !== 1'b1 || o_taken !== 1'b0 || o_mispredict !== 1'b1) begin n_fail++; $display("FAIL illegal_flags: got %0h %0h %0h want 1 0 1", o_illegal, o_taken, o_mispredict); end
      br_keep = o_br_cnt; mis_keep = o_mis_cnt;
      // Stall with a new request pending: the output is held and nothing is accepted.
      drive_req(1'b0, 1'b0, 3'b001, 32'h1, 32'h2, 32'h600, 32'h4, 1'b0, 32'h0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if ({o_valid, o_taken, o_illegal, o_mispredict, o_next_pc} !== {1'b1, e} || ready !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: got %0h rdy %0h want %0h rdy 0", i, {o_valid, o_taken, o_illegal, o_mispredict, o_next_pc}, ready, {1'b1, e}); end
      end
      flush = 1'b1;
      tick();
      n_checks++; if (o_valid !== 1'b0 || o_br_cnt !== br_keep || o_mis_cnt !== mis_keep) begin n_fail++; $display("FAIL flush_clear: got v %0h %0d %0d want 0 %0d %0d", o_valid, o_br_cnt, o_mis_cnt, br_keep, mis_keep); end
      // A flush in the same cycle as a mispredicting request: no shadow follows.
      stall = 1'b0;
      drive_req(1'b0, 1'b0, 3'b000, 32'h3, 32'h3, 32'h700, 32'h10, 1'b0, 32'h0);
      tick();
      n_checks++; if (o_valid !== 1'b0 || o_dbg_state !== 1'b0 || o_br_cnt !== br_keep) begin n_fail++; $display("FAIL flush_mis: got v %0h st %0h cnt %0d want 0 0 %0d", o_valid, o_dbg_state, o_br_cnt, br_keep); end
      flush = 1'b0;
      predict_right();
      tick();
      e = exp_q.pop_front();
      n_checks++; if ({o_valid, o_taken, o_illegal, o_mispredict, o_next_pc} !== {1'b1, e}) begin n_fail++; $display("FAIL after_flush: got %0h want %0h", {o_valid, o_taken, o_illegal, o_mispredict, o_next_pc}, {1'b1, e}); end
      set_idle();
      tick();
   endtask

   task automatic test_random();
      logic [34:0] e;
      logic [31:0] pool [6];
      pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'h7FFF_FFFF;
      pool[3] = 32'h8000_0000; pool[4] = 32'hFFFF_FFFF; pool[5] = 32'h1234_5678;
      for (int i = 0; i < 60; i++) begin
         drive_req(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                   3'($urandom_range(0, 7)), pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
                   $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom);
         valid = ($urandom_range(0, 3) != 0);
         stall = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 1) == 1) predict_right();
         tick();
         if (m_new) begin
            e = exp_q.pop_front();
            held_e = e;
            n_checks++; if ({o_valid, o_taken, o_illegal, o_mispredict, o_next_pc} !== {1'b1, e}) begin n_fail++; $display("FAIL rand_result%0d: got %0h want %0h", i, {o_valid, o_taken, o_illegal, o_mispredict, o_next_pc}, {1'b1, e}); end
         end else if (m_vld) begin
            n_checks++; if ({o_valid, o_taken, o_illegal, o_mispredict, o_next_pc} !== {1'b1, held_e}) begin n_fail++; $display("FAIL rand_hold%0d: got %0h want %0h", i, {o_valid, o_taken, o_illegal, o_mispredict, o_next_pc}, {1'b1, held_e}); end
         end else begin
            n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rand_idle%0d: got %0h want 0", i, o_valid); end
         end
         n_checks++; if (o_br_cnt !== 4'(m_br) || o_mis_cnt !== 4'(m_mis)) begin n_fail++; $display("FAIL rand_counts%0d: got %0d %0d want %0d %0d", i, o_br_cnt, o_mis_cnt, m_br, m_mis); end
      end
      set_idle();
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_reset_mid_shadow();
      drive_req(1'b0, 1'b0, 3'b001, 32'h1, 32'h2, 32'h800, 32'h20, 1'b0, 32'h0);
      tick();
      set_idle();
      n_checks++; if (o_dbg_state !== 1'b1) begin n_fail++; $display("FAIL shadow_entered: got %0h want 1", o_dbg_state); end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++; if (o_valid !== 1'b0 || o_dbg_state !== 1'b0 || o_br_cnt !== 4'd0 || o_mis_cnt !== 4'd0) begin n_fail++; $display("FAIL async_reset: got v %0h st %0h %0d %0d want 0 0 0 0", o_valid, o_dbg_state, o_br_cnt, o_mis_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_saturation();
      logic [34:0] e;
      for (int i = 0; i < 18; i++) begin
         drive_req(1'b0, 1'b0, 3'b101, 32'(i), 32'h8, 32'h1000 + 32'(i * 4), 32'h40, 1'b0, 32'h0);
         predict_right();
         tick();
         e = exp_q.pop_front();
         n_checks++; if ({o_valid, o_taken, o_illegal, o_mispredict, o_next_pc} !== {1'b1, e}) begin n_fail++; $display("FAIL sat_result%0d: got %0h want %0h", i, {o_valid, o_taken, o_illegal, o_mispredict, o_next_pc}, {1'b1, e}); end
         if (i == 16) begin
            n_checks++; if (o_br_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_17th: got %0h want f", o_br_cnt); end
         end
      end
      n_checks++; if (o_br_cnt !== 4'hF || o_mis_cnt !== 4'h0) begin n_fail++; $display("FAIL sat_final: got %0h %0h want f 0", o_br_cnt, o_mis_cnt); end
      set_idle();
      tick();
   endtask

   // Test sequence and report
   initial begin
      n_checks = 0;
      n_fail   = 0;
      held_e   = '0;
      test_reset();
      test_branch_cond();
      test_jalr();
      test_shadow();
      test_illegal_stall_flush();
      test_random();
      test_reset_mid_shadow();
      test_saturation();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL queue_drain: got %0d want 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
